param_data_array: RTL
=====================

PARAM_DATA_ARRAY -- requirements
Module: param_data_array

Interface
REQ-001 SHALL expose parameter NUM_BLOCKS, default 128, number of cache blocks (power of two, >=2).
REQ-002 SHALL expose parameter WORDS_PER_BLOCK, default 8, words per block (power of two, >=2).
REQ-003 SHALL expose parameter DATA_W, default 16, bits per word.
REQ-004 SHALL define derived widths: BW = clog2(NUM_BLOCKS) and WW = clog2(WORDS_PER_BLOCK).
REQ-005 Ports SHALL be as follows:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_en  in  1  read request.
- rd_block  in  BW  read block index.
- rd_word  in  WW  read word index.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_perr  out  1  parity error on the current rd_data.
- wr_en  in  1  single-word write request.
- wr_block  in  BW  write block index.
- wr_word  in  WW  write word index.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  single-word write accepted; equals ~fill_busy.
- fill_start  in  1  begin a line fill.
- fill_block  in  BW  target block for the fill; sampled with fill_start.
- fill_valid  in  1  fill word present.
- fill_data  in  DATA_W  fill word.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse after the last fill word is written.

Function
REQ-006 Reads SHALL have one-cycle latency: rd_en at edge N produces rd_data and rd_valid=1 after edge N+1; rd_valid=0 otherwise, and rd_data holds its last value.
REQ-007 A read SHALL return the contents before any write in the same cycle (read-before-write).
REQ-008 A write with wr_en & wr_ready SHALL update exactly the one addressed word at the edge.
REQ-009 A write with wr_en while wr_ready=0 SHALL be dropped with no state change.
REQ-010 The fill FSM SHALL have states IDLE, FILL and DONE.
REQ-011 In IDLE, fill_start SHALL latch fill_block, clear the word counter and enter FILL.
REQ-012 In FILL, each fill_valid SHALL write fill_data to word[counter] of the latched block and increment the counter; cycles with fill_valid=0 SHALL stall without change.
REQ-013 The word written when counter = WORDS_PER_BLOCK-1 SHALL move the FSM to DONE.
REQ-014 DONE SHALL last one cycle with fill_done=1, then return to IDLE.
REQ-015 fill_busy SHALL be 1 in FILL and DONE.
REQ-016 fill_start outside IDLE SHALL be ignored.
REQ-017 fill_valid in IDLE SHALL be ignored.
REQ-018 A fill_start cycle SHALL write no data, even if fill_valid=1.
REQ-019 Reads SHALL be legal in all states; a read of a word being filled in the same cycle SHALL return the old value.
REQ-020 Out-of-range indices cannot occur, since widths are exact powers of two.

Reset
REQ-021 While rst=0, asynchronously: FSM=IDLE, counter=0, latched block=0, rd_data=0, rd_valid=0, rd_perr=0, fill_busy=0, fill_done=0, and all storage words (and parity bits) cleared to 0.
REQ-022 Reset asserted mid-fill SHALL abandon the fill with no fill_done pulse; wr_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-023 Macro DATA_ARRAY_PARITY_EN defined: each word SHALL store an even-parity bit computed from the write/fill data.
REQ-024 With DATA_ARRAY_PARITY_EN defined, rd_perr SHALL be 1 alongside rd_valid when the stored parity mismatches the stored data.
REQ-025 Macro DATA_ARRAY_PARITY_EN undefined: no parity storage SHALL exist and rd_perr SHALL be tied to 0; all other behaviour is identical.

Verification
REQ-026 Basic write/read: write block 5 word 3 = 0xBEEF, then read block 5 word 3 -> rd_valid=1 and rd_data=0xBEEF exactly one cycle after the read.
REQ-027 Same-cycle read/write: block 0 word 0 holds 0x1111; write 0x2222 and read the same address together -> read returns 0x1111; the next read returns 0x2222.
REQ-028 Fill with stalls: fill_start to block 127, then 8 words 0x0100..0x0107 with fill_valid gaps -> fill_busy=1 throughout, fill_done pulses once, and reads return 0x0100..0x0107.
REQ-029 Write during fill: wr_en during FILL -> wr_ready=0, target word unchanged; a second fill_start mid-fill is ignored, leaving block and counter unaltered.
REQ-030 Reset mid-fill: assert rst after 3 fill words -> FSM=IDLE, no fill_done, all words read 0, and wr_ready=1 after release.
REQ-031 Parity (DATA_ARRAY_PARITY_EN only): force-flip one stored data bit, then read -> rd_perr=1; with the macro undefined, rd_perr stays 0.

Source files
------------

// File: rtl/param_data_array.sv
// Cache data array: single-word read/write port plus a line-fill engine.
// Define DATA_ARRAY_PARITY_EN to store and check an even-parity bit per word.
module param_data_array #(
    parameter int NUM_BLOCKS      = 128,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int DATA_W          = 16,
    localparam int BW = $clog2(NUM_BLOCKS),
    localparam int WW = $clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [BW-1:0]     rd_block,
    input  logic [WW-1:0]     rd_word,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_perr,
    input  logic              wr_en,
    input  logic [BW-1:0]     wr_block,
    input  logic [WW-1:0]     wr_word,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              fill_start,
    input  logic [BW-1:0]     fill_block,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data,
    output logic              fill_busy,
    output logic              fill_done
);

    localparam int DEPTH = NUM_BLOCKS * WORDS_PER_BLOCK;
    localparam int AW    = BW + WW;
    localparam logic [WW-1:0] LAST = WW'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     cnt_q;
    logic [BW-1:0]     blk_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              fill_we;
    logic              word_we;
    logic [AW-1:0]     fill_addr;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;

    assign fill_addr = {blk_q, cnt_q};
    assign wr_addr   = {wr_block, wr_word};
    assign rd_addr   = {rd_block, rd_word};

    always_comb begin
        state_d   = state_q;
        fill_busy = 1'b0;
        fill_done = 1'b0;
        fill_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fill_start) state_d = FILL;
            end
            FILL: begin
                fill_busy = 1'b1;
                fill_we   = fill_valid;
                if (fill_valid && cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                fill_busy = 1'b1;
                fill_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_ready = ~fill_busy;
    assign word_we  = wr_en & wr_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && fill_start) begin
                blk_q <= fill_block;
                cnt_q <= '0;
            end else if (fill_we) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Fill and single-word writes are mutually exclusive: wr_ready is low in FILL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (fill_we) begin
            mem[fill_addr] <= fill_data;
        end else if (word_we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= mem[rd_addr];
        end
    end

`ifdef DATA_ARRAY_PARITY_EN
    logic par [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) par[i] <= 1'b0;
        end else if (fill_we) begin
            par[fill_addr] <= ^fill_data;
        end else if (word_we) begin
            par[wr_addr] <= ^wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_perr <= 1'b0;
        end else begin
            rd_perr <= rd_en & ((^mem[rd_addr]) ^ par[rd_addr]);
        end
    end
`else
    assign rd_perr = 1'b0;
`endif

endmodule
